// File: rtl/uart_wb_master_pkg.sv
// Shared types and constants for the UART-driven Wishbone debug master.
package uart_wb_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP
    } state_e;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam int TMO_W = 16;

    // Single-byte responses ride in the top byte so the serialiser always sends MSB first.
    function automatic logic [DAT_W-1:0] rsp_word(input logic [7:0] rsp);
        return {rsp, 24'h00_0000};
    endfunction

endpackage

// File: rtl/uart_wb_master_if.sv
// Byte-stream and Wishbone signals of the UART Wishbone master, bundled as one interface.
interface uart_wb_master_if;
    import uart_wb_master_pkg::*;

    logic [7:0]       rx_data_i;
    logic             rx_valid_i;
    logic             rx_ready_o;

    logic [7:0]       tx_data_o;
    logic             tx_valid_o;
    logic             tx_ready_i;

    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [ADR_W-1:0] wbm_adr_o;
    logic [DAT_W-1:0] wbm_dat_o;
    logic [SEL_W-1:0] wbm_sel_o;
    logic             wbm_ack_i;
    logic [DAT_W-1:0] wbm_dat_i;

    logic             busy_o;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, wbm_ack_i, wbm_dat_i,
        output rx_ready_o, tx_data_o, tx_valid_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output busy_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, wbm_ack_i, wbm_dat_i,
        input  rx_ready_o, tx_data_o, tx_valid_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  busy_o
    );

endinterface

// File: rtl/uart_wb_master_txser.sv
// Response serialiser: loads a 32-bit word with a 1- or 4-byte count and emits it MSB first
// over a valid/ready byte handshake, pulsing done_o as the final byte is accepted.
module uart_wb_master_txser
    import uart_wb_master_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DAT_W-1:0] word_i,
    input  logic             four_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             done_o
);

    logic [DAT_W-1:0] word_q, word_d;
    logic [2:0]       remain_q, remain_d;
    logic             valid_q, valid_d;

    always_comb begin
        word_d   = word_q;
        remain_d = remain_q;
        valid_d  = valid_q;
        done_o   = 1'b0;
        if (load_i) begin
            word_d   = word_i;
            remain_d = four_i ? 3'd4 : 3'd1;
            valid_d  = 1'b1;
        end else if (valid_q && tx_ready_i) begin
            word_d   = {word_q[DAT_W-9:0], 8'h00};
            remain_d = remain_q - 3'd1;
            if (remain_q == 3'd1) begin
                valid_d = 1'b0;
                done_o  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q   <= '0;
            remain_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            word_q   <= word_d;
            remain_q <= remain_d;
            valid_q  <= valid_d;
        end
    end

    assign tx_data_o  = word_q[DAT_W-1:DAT_W-8];
    assign tx_valid_o = valid_q;

endmodule

// File: rtl/uart_wb_master.sv
// UART byte-stream to Wishbone single-cycle master ('W' write / 'R' read commands).
// Optional ack timeout enabled with `define UART_WB_MASTER_TIMEOUT_EN.
module uart_wb_master
    import uart_wb_master_pkg::*;
#(
    parameter logic [SEL_W-1:0] SEL_DEFAULT    = 4'hF,
    parameter int               TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    uart_wb_master_if.master ifc
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("uart_wb_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             we_q, we_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
`ifdef UART_WB_MASTER_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    logic             rx_ready;
    logic             rx_fire;
    logic             tx_load;
    logic [DAT_W-1:0] tx_word;
    logic             tx_four;
    logic             tx_done;
    logic [7:0]       tx_data;
    logic             tx_valid;

    assign rx_ready = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
    assign rx_fire  = ifc.rx_valid_i && rx_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        tx_load = 1'b0;
        tx_word = '0;
        tx_four = 1'b0;
`ifdef UART_WB_MASTER_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    cnt_d = 2'd0;
                    if (ifc.rx_data_i == CMD_WR) begin
                        we_d    = 1'b1;
                        state_d = ADDR;
                    end else if (ifc.rx_data_i == CMD_RD) begin
                        we_d    = 1'b0;
                        state_d = ADDR;
                    end else begin
                        tx_load = 1'b1;
                        tx_word = rsp_word(RSP_NAK);
                        state_d = RESP;
                    end
                end
            end
            ADDR: begin
                if (rx_fire) begin
                    adr_d = {adr_q[ADR_W-9:0], ifc.rx_data_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (we_q) begin
                            state_d = DATA;
                        end else begin
                            state_d = BUS;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            sel_d   = SEL_DEFAULT;
`ifdef UART_WB_MASTER_TIMEOUT_EN
                            tmo_d   = '0;
`endif
                        end
                    end
                end
            end
            DATA: begin
                if (rx_fire) begin
                    dat_d = {dat_q[DAT_W-9:0], ifc.rx_data_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        sel_d   = SEL_DEFAULT;
`ifdef UART_WB_MASTER_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            BUS: begin
                // Ack on the very first BUS cycle is honoured, giving one-cycle minimum latency.
                if (ifc.wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    sel_d   = '0;
                    tx_load = 1'b1;
                    tx_word = we_q ? rsp_word(RSP_ACK) : ifc.wbm_dat_i;
                    tx_four = !we_q;
                    state_d = RESP;
                end
`ifdef UART_WB_MASTER_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    sel_d   = '0;
                    tx_load = 1'b1;
                    tx_word = rsp_word(RSP_NAK);
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            RESP: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
`ifdef UART_WB_MASTER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
`ifdef UART_WB_MASTER_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    uart_wb_master_txser u_txser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tx_load),
        .word_i     (tx_word),
        .four_i     (tx_four),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (ifc.tx_ready_i),
        .done_o     (tx_done)
    );

    assign ifc.rx_ready_o = rx_ready;
    assign ifc.tx_data_o  = tx_data;
    assign ifc.tx_valid_o = tx_valid;
    assign ifc.wbm_cyc_o  = cyc_q;
    assign ifc.wbm_stb_o  = stb_q;
    assign ifc.wbm_we_o   = we_q;
    assign ifc.wbm_adr_o  = adr_q;
    assign ifc.wbm_dat_o  = dat_q;
    assign ifc.wbm_sel_o  = sel_q;
    assign ifc.busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed self-checking bench for uart_wb_master: write, read, NAK, backpressure, reset, timeout.
module tb_uart_wb_master;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    uart_wb_master_if ifc ();

    uart_wb_master #(
        .SEL_DEFAULT    (4'hF),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ifc   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        ifc.rx_data_i  = b;
        ifc.rx_valid_i = 1'b1;
        while (ifc.rx_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ifc.rx_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rx_accept: rx_ready_o=%b required 1", ifc.rx_ready_o);
        end
        @(posedge clk); #1;
        ifc.rx_valid_i = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
        send_byte(cmd);
        for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
        if (cmd == 8'h57) begin
            for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
        end
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        ifc.tx_ready_i = 1'b1;
        while (ifc.tx_valid_o !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (ifc.tx_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tx_wait: tx_valid_o=%b required 1", ifc.tx_valid_o);
            b = 8'h00;
        end else begin
            b = ifc.tx_data_o;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        checks++; if (ifc.rx_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_rx_ready: got %b need 1", ifc.rx_ready_o); end
        checks++; if (ifc.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b need 0", ifc.busy_o); end
        checks++; if (ifc.wbm_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_cyc: got %b need 0", ifc.wbm_cyc_o); end
        checks++; if (ifc.tx_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b need 0", ifc.tx_valid_o); end
        checks++; if (ifc.wbm_adr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_adr: got %h need 0", ifc.wbm_adr_o); end
        checks++; if (ifc.wbm_sel_o !== 4'h0) begin errors++; $display("[TB] FAIL reset_sel: got %h need 0", ifc.wbm_sel_o); end
    endtask

    task automatic test_write;
        logic [7:0] b;
        send_cmd(8'h57, 32'h3001_0004, 32'hDEAD_BEEF);
        checks++; if (ifc.wbm_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_cyc: got %b need 1", ifc.wbm_cyc_o); end
        checks++; if (ifc.wbm_stb_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_stb: got %b need 1", ifc.wbm_stb_o); end
        checks++; if (ifc.wbm_we_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_we: got %b need 1", ifc.wbm_we_o); end
        checks++; if (ifc.wbm_adr_o !== 32'h3001_0004) begin errors++; $display("[TB] FAIL wr_adr: got %h need 30010004", ifc.wbm_adr_o); end
        checks++; if (ifc.wbm_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wr_dat: got %h need deadbeef", ifc.wbm_dat_o); end
        checks++; if (ifc.wbm_sel_o !== 4'hF) begin errors++; $display("[TB] FAIL wr_sel: got %h need f", ifc.wbm_sel_o); end
        checks++; if (ifc.rx_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL wr_rx_ready_bus: got %b need 0", ifc.rx_ready_o); end
        repeat (2) begin
            @(posedge clk); #1;
            checks++; if (ifc.wbm_cyc_o !== 1'b1 || ifc.wbm_stb_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_cyc_hold: cyc=%b stb=%b need 1", ifc.wbm_cyc_o, ifc.wbm_stb_o); end
        end
        ifc.wbm_ack_i = 1'b1;
        @(posedge clk); #1;
        ifc.wbm_ack_i = 1'b0;
        checks++; if (ifc.wbm_cyc_o !== 1'b0 || ifc.wbm_stb_o !== 1'b0) begin errors++; $display("[TB] FAIL wr_cyc_drop: cyc=%b stb=%b need 0", ifc.wbm_cyc_o, ifc.wbm_stb_o); end
        checks++; if (ifc.busy_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_busy_resp: got %b need 1", ifc.busy_o); end
        recv_byte(b);
        checks++; if (b !== 8'h06) begin errors++; $display("[TB] FAIL wr_resp: got %h need 06", b); end
        checks++; if (ifc.busy_o !== 1'b0 || ifc.rx_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_idle: busy=%b rx_ready=%b need 0/1", ifc.busy_o, ifc.rx_ready_o); end
        checks++; if (ifc.tx_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL wr_tx_idle: got %b need 0", ifc.tx_valid_o); end
    endtask

    task automatic read_cycle(input logic [31:0] adr, input logic [31:0] rdata, input logic [31:0] exp_resp);
        logic [7:0] b;
        send_cmd(8'h52, adr, 32'h0);
        checks++; if (ifc.wbm_cyc_o !== 1'b1 || ifc.wbm_we_o !== 1'b0) begin errors++; $display("[TB] FAIL rd_cyc_we: cyc=%b we=%b need 1/0", ifc.wbm_cyc_o, ifc.wbm_we_o); end
        checks++; if (ifc.wbm_adr_o !== adr) begin errors++; $display("[TB] FAIL rd_adr: got %h need %h", ifc.wbm_adr_o, adr); end
        ifc.wbm_ack_i = 1'b1;
        ifc.wbm_dat_i = rdata;
        @(posedge clk); #1;
        ifc.wbm_ack_i = 1'b0;
        ifc.wbm_dat_i = 32'h0;
        checks++; if (ifc.wbm_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL rd_cyc_drop: got %b need 0", ifc.wbm_cyc_o); end
        for (int i = 3; i >= 0; i--) begin
            recv_byte(b);
            checks++; if (b !== exp_resp[i*8 +: 8]) begin errors++; $display("[TB] FAIL rd_byte%0d: got %h need %h", 3 - i, b, exp_resp[i*8 +: 8]); end
        end
        checks++; if (ifc.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rd_idle: busy=%b need 0", ifc.busy_o); end
    endtask

    task automatic test_read;
        read_cycle(32'h3001_0008, 32'h1234_5678, 32'h1234_5678);
    endtask

    task automatic test_illegal;
        logic [7:0] b;
        send_byte(8'hA5);
        checks++; if (ifc.wbm_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL nak_no_cyc: got %b need 0", ifc.wbm_cyc_o); end
        checks++; if (ifc.busy_o !== 1'b1 || ifc.rx_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL nak_resp_state: busy=%b rx_ready=%b need 1/0", ifc.busy_o, ifc.rx_ready_o); end
        recv_byte(b);
        checks++; if (b !== 8'h15) begin errors++; $display("[TB] FAIL nak_byte: got %h need 15", b); end
        checks++; if (ifc.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL nak_idle: got %b need 0", ifc.busy_o); end
        read_cycle(32'h3001_000C, 32'hCAFE_F00D, 32'hCAFE_F00D);
    endtask

    task automatic test_backpressure;
        logic [7:0] b;
        logic [31:0] exp_resp;
        exp_resp = 32'h1234_5678;
        ifc.tx_ready_i = 1'b0;
        send_cmd(8'h52, 32'h3001_0008, 32'h0);
        ifc.wbm_ack_i = 1'b1;
        ifc.wbm_dat_i = 32'h1234_5678;
        @(posedge clk); #1;
        ifc.wbm_ack_i = 1'b0;
        ifc.wbm_dat_i = 32'h0;
        for (int i = 0; i < 10; i++) begin
            checks++; if (ifc.tx_valid_o !== 1'b1 || ifc.tx_data_o !== 8'h12) begin errors++; $display("[TB] FAIL bp_hold%0d: valid=%b data=%h need 1/12", i, ifc.tx_valid_o, ifc.tx_data_o); end
            checks++; if (ifc.rx_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_rx_ready%0d: got %b need 0", i, ifc.rx_ready_o); end
            @(posedge clk); #1;
        end
        for (int i = 3; i >= 0; i--) begin
            recv_byte(b);
            checks++; if (b !== exp_resp[i*8 +: 8]) begin errors++; $display("[TB] FAIL bp_byte%0d: got %h need %h", 3 - i, b, exp_resp[i*8 +: 8]); end
        end
        checks++; if (ifc.tx_valid_o !== 1'b0 || ifc.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_extra: valid=%b busy=%b need 0/0", ifc.tx_valid_o, ifc.busy_o); end
    endtask

    task automatic test_ack_ignored;
        ifc.wbm_ack_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (ifc.busy_o !== 1'b0 || ifc.wbm_cyc_o !== 1'b0 || ifc.tx_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack: busy=%b cyc=%b tx_valid=%b need 0", ifc.busy_o, ifc.wbm_cyc_o, ifc.tx_valid_o); end
        end
        ifc.wbm_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        send_cmd(8'h57, 32'h3001_0010, 32'h1122_3344);
        checks++; if (ifc.wbm_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_cyc: got %b need 1", ifc.wbm_cyc_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ifc.wbm_cyc_o !== 1'b0 || ifc.wbm_stb_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_cyc: cyc=%b stb=%b need 0", ifc.wbm_cyc_o, ifc.wbm_stb_o); end
        checks++; if (ifc.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_busy: got %b need 0", ifc.busy_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (ifc.rx_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_rx_ready: got %b need 1", ifc.rx_ready_o); end
        checks++; if (ifc.wbm_adr_o !== 32'h0 || ifc.wbm_dat_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_cleared: adr=%h dat=%h need 0", ifc.wbm_adr_o, ifc.wbm_dat_o); end
        send_cmd(8'h57, 32'h3001_0014, 32'h5566_7788);
        checks++; if (ifc.wbm_adr_o !== 32'h3001_0014 || ifc.wbm_dat_o !== 32'h5566_7788) begin errors++; $display("[TB] FAIL rst_new_wr: adr=%h dat=%h need 30010014/55667788", ifc.wbm_adr_o, ifc.wbm_dat_o); end
        ifc.wbm_ack_i = 1'b1;
        @(posedge clk); #1;
        ifc.wbm_ack_i = 1'b0;
        recv_byte(b);
        checks++; if (b !== 8'h06) begin errors++; $display("[TB] FAIL rst_new_resp: got %h need 06", b); end
    endtask

`ifdef UART_WB_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        logic [7:0] b;
        int hi = 0;
        send_cmd(8'h52, 32'h3001_0018, 32'h0);
        while (ifc.wbm_cyc_o === 1'b1 && hi < 100) begin
            hi++;
            @(posedge clk); #1;
        end
        checks++; if (hi != 16) begin errors++; $display("[TB] FAIL tmo_cycles: got %0d need 16", hi); end
        recv_byte(b);
        checks++; if (b !== 8'h15) begin errors++; $display("[TB] FAIL tmo_resp: got %h need 15", b); end
        checks++; if (ifc.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL tmo_idle: got %b need 0", ifc.busy_o); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst            = 1'b1;
        ifc.rx_data_i  = 8'h00;
        ifc.rx_valid_i = 1'b0;
        ifc.tx_ready_i = 1'b1;
        ifc.wbm_ack_i  = 1'b0;
        ifc.wbm_dat_i  = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        test_reset;
        test_write;
        test_read;
        test_illegal;
        test_backpressure;
        test_ack_ignored;
        test_reset_mid;
`ifdef UART_WB_MASTER_TIMEOUT_EN
        test_timeout;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Wishbone initiator driven by a byte stream: decodes read/write commands from the UART RX byte path and issues single classic Wishbone cycles.
- Serialises responses back onto the UART TX byte path.
- Sits between the UART byte interface and the user-area Wishbone bus, acting as a debug/bring-up master for peripherals such as the UART slave at 0x3001_0000.

Parameters:
- SEL_DEFAULT, 4'hF, byte-select driven on every cycle.
- TIMEOUT_CYCLES, 255, Wishbone ack timeout in clk_i cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- rx_data_i  in  8  received command byte.
- rx_valid_i  in  1  rx_data_i valid.
- rx_ready_o  out  1  bridge accepts byte; transfer when rx_valid_i&rx_ready_o.
- tx_data_o  out  8  response byte.
- tx_valid_o  out  1  tx_data_o valid.
- tx_ready_i  in  1  sink accepts byte; transfer when tx_valid_o&tx_ready_i.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte select.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  read data.
- busy_o  out  1  high in any state except IDLE.

Behaviour:
- Reset: all outputs 0 except rx_ready_o=1 (IDLE). Internal address/data/counters cleared.
- Reset mid-operation: state returns to IDLE asynchronously; wbm_cyc_o/stb_o drop immediately. A partial command or response is discarded.
- Command format:
  - 0x57 'W' + 4 address bytes MSB first + 4 data bytes MSB first.
  - 0x52 'R' + 4 address bytes MSB first.
- Any other byte in IDLE: consumed, response 0x15 (NAK), return to IDLE.
- FSM states: IDLE -> ADDR (byte cnt 0..3) -> DATA (writes only, cnt 0..3) -> BUS -> RESP -> IDLE.
- rx_ready_o=1 only in IDLE/ADDR/DATA; 0 in BUS/RESP.
- Byte shift: addr <= {addr[23:0], rx_data_i} on each accepted byte; data shifts the same way. The 2-bit counter wraps 3->0 when leaving the state.
- BUS:
  - wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o are registered.
  - cyc/stb assert the cycle after the last command byte is accepted and hold stable until the first clk_i edge with wbm_ack_i=1.
  - On that edge: cyc/stb deassert, wbm_dat_i is captured (reads), and the FSM moves to RESP.
  - Exactly one cycle per command; no pipelining; wbm_adr_o is unmodified (no alignment check).
- RESP:
  - Write: one byte 0x06 (ACK).
  - Read: 4 bytes, read data MSB first.
  - tx_valid_o held with tx_data_o stable until accepted; next byte presented the cycle after acceptance.
  - Return to IDLE the cycle after the last byte is accepted.
- Simultaneous events:
  - An ack arriving the same cycle cyc is first asserted is honoured (minimum bus latency 1 cycle).
  - wbm_ack_i outside BUS is ignored.
- Throughput: one RX byte per cycle max; one TX byte per cycle max.

Optional Feature:
- Macro UART_WB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter runs in BUS. If TIMEOUT_CYCLES elapse without ack, cyc/stb deassert and the response is the single byte 0x15 for both reads and writes.
  - Counter clears on entering BUS.
- Undefined: no counter; BUS waits for ack indefinitely.

Decomposition:
- Package uart_wb_master_pkg:
  - State enum (IDLE, ADDR, DATA, BUS, RESP).
  - Constants CMD_WR=8'h57, CMD_RD=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15.
- One sub-module, uart_wb_master_txser: loads a 32-bit word plus byte count (1 or 4), shifts out MSB-first bytes with a valid/ready handshake, and pulses done.

Test Plan:
- Write: send 57 30 01 00 04 DE AD BE EF, slave acks after 3 cycles -> one cycle with adr=0x3001_0004, dat=0xDEADBEEF, we=1, sel=F; TX emits 06.
- Read: send 52 30 01 00 08, slave returns 0x12345678 with immediate ack -> we=0, adr=0x3001_0008; TX emits 12 34 56 78.
- Illegal byte 0xA5 in IDLE -> no Wishbone cycle; TX emits 15; a following valid read succeeds.
- Backpressure: tx_ready_i low 10 cycles during read response -> tx_valid_o/tx_data_o held at 0x12; no byte lost or duplicated; rx_ready_o=0 throughout.
- Reset asserted while cyc=1 -> cyc/stb/busy_o go 0 without a clock edge; after release rx_ready_o=1 and a new write completes.
- With UART_WB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16: read with no ack -> cyc drops after 16 cycles; TX emits 15.
